mem_access_unit: RTL and testbench

- Memory-access stage directly downstream of the EX/MEM memory-control pipeline register; consumes its registered CSN/WEN/BE plus address, store data and load-sign controls.
- Aligns store data and byte enables onto the 32-bit data-memory port and sequences loads against a fixed-latency synchronous memory.
- Extracts and sign- or zero-extends load results and drives STALL, which upstream uses as its register ENABLE, inverted.

---
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit.sv | 64 ++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request side, data-memory port and load-result signals of the memory-access stage.
interface mem_access_unit_if #(parameter int ADDR_WIDTH = 12);
  logic                  REQ_CSN;
  logic                  REQ_WEN;
  logic [3:0]            REQ_BE;
  logic [31:0]           REQ_ADDR;
  logic [31:0]           REQ_WDATA;
  logic                  REQ_UNSIGNED;
  logic                  D_MEM_CSN;
  logic                  D_MEM_WEN;
  logic [3:0]            D_MEM_BE;
  logic [ADDR_WIDTH-1:0] D_MEM_ADDR;
  logic [31:0]           D_MEM_DOUT;
  logic [31:0]           D_MEM_DI;
  logic                  STALL;
  logic [31:0]           LOAD_DATA;
  logic                  LOAD_VALID;
  logic                  MISALIGN;
  modport slave (
    input  REQ_CSN, REQ_WEN, REQ_BE, REQ_ADDR, REQ_WDATA, REQ_UNSIGNED, D_MEM_DI,
    output D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT, STALL, LOAD_DATA, LOAD_VALID, MISALIGN
  );
  modport master (
    output REQ_CSN, REQ_WEN, REQ_BE, REQ_ADDR, REQ_WDATA, REQ_UNSIGNED, D_MEM_DI,
    input  D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT, STALL, LOAD_DATA, LOAD_VALID, MISALIGN
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: aligns stores onto a 32-bit memory port and sequences fixed-latency loads with extension.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 1
) (
  input logic CLK,
  input logic RST,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off, off_q;
  logic [3:0]    be_q;
  logic          uns_q, mis, acc, unused_addr;
  logic [31:0]   r, ext;
  assign off = bus.REQ_ADDR[1:0];
  assign mis = !(bus.REQ_BE == 4'b0001 || (bus.REQ_BE == 4'b0011 && off != 2'd3) || (bus.REQ_BE == 4'b1111 && off == 2'd0));
  // Requests reach memory only from IDLE; WAIT and reset hold the port idle.
  assign acc = !RST && state == IDLE && !bus.REQ_CSN && !mis;
  assign bus.D_MEM_CSN  = !acc;
  assign bus.D_MEM_WEN  = !(acc && !bus.REQ_WEN);
  assign bus.D_MEM_BE   = acc ? bus.REQ_BE << off : 4'b0000;
  assign bus.D_MEM_ADDR = bus.REQ_ADDR[ADDR_WIDTH+1:2];
  assign bus.D_MEM_DOUT = bus.REQ_WDATA << {off, 3'b000};
  assign bus.STALL      = (acc && bus.REQ_WEN) || state == WAIT;
  assign unused_addr    = ^bus.REQ_ADDR[31:ADDR_WIDTH+2];
  assign r   = bus.D_MEM_DI >> {off_q, 3'b000};
  assign ext = be_q[3] ? r :
               be_q[1] ? {{16{!uns_q && r[15]}}, r[15:0]} :
                         {{24{!uns_q && r[7]}}, r[7:0]};
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      off_q          <= '0;
      be_q           <= '0;
      uns_q          <= 1'b0;
      bus.LOAD_VALID <= 1'b0;
      bus.LOAD_DATA  <= '0;
      bus.MISALIGN   <= 1'b0;
    end else begin
      bus.MISALIGN   <= state == IDLE && !bus.REQ_CSN && mis;
      bus.LOAD_VALID <= 1'b0;
      if (state == IDLE) begin
        if (acc && bus.REQ_WEN) begin
          state <= WAIT;
          cnt   <= CW'(MEM_LATENCY);
          off_q <= off;
          be_q  <= bus.REQ_BE;
          uns_q <= bus.REQ_UNSIGNED;
        end
      end else begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state          <= IDLE;
          bus.LOAD_VALID <= 1'b1;
          bus.LOAD_DATA  <= ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: three latency variants (1,2,3) driven in lockstep against a byte-level memory model.
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        req_csn = 1'b1, req_wen = 1'b1, req_uns = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] mem [256];
  logic [31:0] junk = '0;
  always @(posedge clk) junk <= $urandom;
  logic        o_csn [3], o_wen [3], o_stall [3], o_lv [3], o_mis [3];
  logic [3:0]  o_be [3];
  logic [11:0] o_addr [3];
  logic [31:0] o_dout [3], o_ld [3];
  int total = 0, bad = 0;

  for (genvar g = 0; g < 3; g++) begin : d
    mem_access_unit_if #(.ADDR_WIDTH(12)) bus ();
    logic [3:0] pv = '0;
    logic [7:0] pa [4];
    mem_access_unit #(.ADDR_WIDTH(12), .MEM_LATENCY(g + 1)) dut (.CLK(clk), .RST(rst), .bus(bus));
    assign bus.REQ_CSN      = req_csn;
    assign bus.REQ_WEN      = req_wen;
    assign bus.REQ_BE       = req_be;
    assign bus.REQ_ADDR     = req_addr;
    assign bus.REQ_WDATA    = req_wdata;
    assign bus.REQ_UNSIGNED = req_uns;
    // Read data is valid only in the cycle MEM_LATENCY after the request; junk otherwise.
    assign bus.D_MEM_DI = pv[g] ? mem[pa[g]] : junk;
    assign o_csn[g]   = bus.D_MEM_CSN;
    assign o_wen[g]   = bus.D_MEM_WEN;
    assign o_be[g]    = bus.D_MEM_BE;
    assign o_addr[g]  = bus.D_MEM_ADDR;
    assign o_dout[g]  = bus.D_MEM_DOUT;
    assign o_stall[g] = bus.STALL;
    assign o_lv[g]    = bus.LOAD_VALID;
    assign o_ld[g]    = bus.LOAD_DATA;
    assign o_mis[g]   = bus.MISALIGN;
    always @(posedge clk) begin
      pv    <= {pv[2:0], !bus.D_MEM_CSN && bus.D_MEM_WEN};
      pa[0] <= bus.D_MEM_ADDR[7:0];
      for (int k = 1; k < 4; k++) pa[k] <= pa[k-1];
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", nm, g, act, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] be);
    return be == 4'b0001 ? 1 : be == 4'b0011 ? 2 : be == 4'b1111 ? 4 : 0;
  endfunction

  // One isolated access; checks cycle-by-cycle behaviour of all three latencies against the model.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                        input logic wen, input logic uns,
                        output logic [3:0] s_be, output logic [31:0] s_dout, output logic [31:0] s_ld);
    int n, off, lat;
    bit misal, ld, st;
    logic [3:0]  e_be;
    logic [31:0] e_dout, e_ld, w;
    n = size_of(be);
    off = int'(addr[1:0]);
    misal = (n == 0) || (off + n > 4);
    ld = !misal && wen;
    st = !misal && !wen;
    e_be = '0; e_dout = '0; e_ld = '0;
    w = mem[addr[9:2]];
    for (int i = 0; i < 4 - off; i++) e_dout[8*(off+i) +: 8] = wdata[8*i +: 8];
    for (int i = 0; i < n; i++) begin
      e_be[off+i] = 1'b1;
      e_ld[8*i +: 8] = w[8*(off+i) +: 8];
    end
    if (!uns && n > 0 && n < 4 && e_ld[8*n-1]) for (int i = n; i < 4; i++) e_ld[8*i +: 8] = 8'hFF;
    req_addr = addr; req_wdata = wdata; req_be = be; req_wen = wen; req_uns = uns; req_csn = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("req_csn", g, o_csn[g], !(ld || st));
      chk("req_wen", g, o_wen[g], !st);
      chk("req_be", g, o_be[g], (ld || st) ? e_be : 4'h0);
      chk("req_stall", g, o_stall[g], ld);
      if (ld || st) chk("req_addr", g, o_addr[g], addr[13:2]);
      if (st) chk("req_dout", g, o_dout[g], e_dout);
    end
    s_be = o_be[1]; s_dout = o_dout[1]; s_ld = '0;
    if (st) for (int i = 0; i < n; i++) mem[addr[9:2]][8*(off+i) +: 8] = wdata[8*i +: 8];
    @(posedge clk); #1;
    req_csn = 1'b1; req_addr = $urandom; req_be = 4'($urandom); req_uns = 1'($urandom); req_wen = 1'($urandom);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        lat = g + 1;
        chk("stall", g, o_stall[g], ld && c <= lat);
        chk("load_valid", g, o_lv[g], ld && c == lat + 1);
        chk("misalign", g, o_mis[g], misal && c == 1);
        chk("csn_after", g, o_csn[g], 1'b1);
        if (ld && c == lat + 1) chk("load_data", g, o_ld[g], e_ld);
      end
      if (ld && c == 2) s_ld = o_ld[0];
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        wen, uns;
    logic [3:0]  e_be;
    logic [31:0] e_dout, e_ld;
  } vec_t;
  vec_t tab [12];

  initial begin
    logic [3:0]  s_be;
    logic [31:0] s_dout, s_ld, e_a, e_b;
    int r;
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  s_be;
    logic [31:0] s_dout, s_ld;
    logic [3:0]  rb;
    int r;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    tab[0]  = '{32'h6, 32'h0000_00AB, 4'b0001, 1'b0, 1'b0, 4'b0100, 32'h00AB_0000, 32'h0};
    tab[1]  = '{32'h0, 32'h8001_1234, 4'b1111, 1'b0, 1'b0, 4'b1111, 32'h8001_1234, 32'h0};
    tab[2]  = '{32'h2, 32'h0,         4'b0011, 1'b1, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001};
    tab[3]  = '{32'h2, 32'h0,         4'b0011, 1'b1, 1'b1, 4'b1100, 32'h0, 32'h0000_8001};
    tab[4]  = '{32'h4, 32'h0000_F000, 4'b1111, 1'b0, 1'b0, 4'b1111, 32'h0000_F000, 32'h0};
    tab[5]  = '{32'h5, 32'h0,         4'b0001, 1'b1, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FFF0};
    tab[6]  = '{32'h5, 32'h0,         4'b1111, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0};
    tab[7]  = '{32'h3, 32'h1111_2222, 4'b0011, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0};
    tab[8]  = '{32'h0, 32'h1111_2222, 4'b0101, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0};
    tab[9]  = '{32'hA, 32'h1234_BEEF, 4'b0011, 1'b0, 1'b0, 4'b1100, 32'hBEEF_0000, 32'h0};
    tab[10] = '{32'h8, 32'h0,         4'b1111, 1'b1, 1'b0, 4'b1111, 32'h0, 32'hBEEF_0000};
    tab[11] = '{32'hB, 32'h0,         4'b0001, 1'b1, 1'b1, 4'b1000, 32'h0, 32'h0000_00BE};
    // Reset state with an aligned store presented: the port must stay idle.
    req_csn = 1'b0; req_wen = 1'b0; req_be = 4'hF; req_addr = 32'h0; req_wdata = 32'h5555_5555;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_csn", g, o_csn[g], 1'b1);
      chk("rst_wen", g, o_wen[g], 1'b1);
      chk("rst_be", g, o_be[g], 4'h0);
      chk("rst_stall", g, o_stall[g], 1'b0);
      chk("rst_lv", g, o_lv[g], 1'b0);
      chk("rst_ld", g, o_ld[g], 32'h0);
      chk("rst_mis", g, o_mis[g], 1'b0);
    end
    req_csn = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      access(tab[i].addr, tab[i].wdata, tab[i].be, tab[i].wen, tab[i].uns, s_be, s_dout, s_ld);
      if (!tab[i].wen && tab[i].e_be != 4'h0) begin
        chk($sformatf("tab%0d_be", i), 1, s_be, tab[i].e_be);
        chk($sformatf("tab%0d_dout", i), 1, s_dout, tab[i].e_dout);
      end
      if (tab[i].wen && tab[i].e_be != 4'h0) chk($sformatf("tab%0d_ld", i), 0, s_ld, tab[i].e_ld);
    end
    // Back-to-back loads on latency 2, with ignored store requests presented during WAIT.
    for (int c = 0; c < 8; c++) begin
      req_csn = 1'b0;
      if (c == 0) begin req_addr = 32'h0; req_be = 4'hF; req_wen = 1'b1; req_uns = 1'b0; end
      else if (c == 3) begin req_addr = 32'hA; req_be = 4'h3; req_wen = 1'b1; req_uns = 1'b1; end
      else if (c < 3) begin req_addr = 32'h10; req_be = 4'hF; req_wen = 1'b0; req_wdata = $urandom; end
      else req_csn = 1'b1;
      @(negedge clk);
      chk("b2b_csn", 1, o_csn[1], !(c == 0 || c == 3));
      chk("b2b_stall", 1, o_stall[1], c <= 5);
      chk("b2b_lv", 1, o_lv[1], c == 3 || c == 6);
      if (c >= 3 && c < 6) chk("b2b_ld_a", 1, o_ld[1], 32'h8001_1234);
      if (c >= 6) chk("b2b_ld_b", 1, o_ld[1], 32'h0000_BEEF);
      @(posedge clk); #1;
    end
    req_csn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    // Reset asserted while latency-3 unit is waiting.
    req_csn = 1'b0; req_addr = 32'h0; req_be = 4'hF; req_wen = 1'b1; req_uns = 1'b0;
    @(posedge clk); #1; req_csn = 1'b1;
    @(negedge clk);
    chk("midwait_stall_pre", 2, o_stall[2], 1'b1);
    @(posedge clk); #1; rst = 1'b1; #2;
    chk("midwait_stall_rst", 2, o_stall[2], 1'b0);
    chk("midwait_lv_rst", 2, o_lv[2], 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midwait_lv_after", 2, o_lv[2], 1'b0);
      chk("midwait_stall_after", 2, o_stall[2], 1'b0);
    end
    @(posedge clk); #1;
    access(32'h2, 32'h0, 4'b0011, 1'b1, 1'b0, s_be, s_dout, s_ld);
    chk("midwait_next_ld", 0, s_ld, 32'hFFFF_8001);
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      rb = r < 3 ? 4'b0001 : r < 6 ? 4'b0011 : r < 9 ? 4'b1111 : 4'($urandom);
      access(32'($urandom_range(0, 1023)), $urandom, rb, 1'($urandom), 1'($urandom), s_be, s_dout, s_ld);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
